sm_mcu_cpu_dct_packer: RTL and testbench
========================================

// Module: sm_mcu_cpu_dct_packer
// PURPOSE
//  Trace-compression packer for the CPU on-chip-instrumentation (OCI) path. Accepts 2-bit
//  compressed trace atoms from the trace-atom encoder, one per cycle, and packs up to 15 of them
//  into a 30-bit DCT frame. Presents each frame (dct_buffer, dct_count) to the downstream OCI
//  trace writer / test bench consumer over a valid/ready handshake. Closes partial frames on
//  flush, test_ending or idle timeout.
// PARAMETERS
//  ATOM_W   2    bits per atom (fixed; checked by package constant)
//  SLOTS    15   atoms per frame; dct_buffer width = ATOM_W*SLOTS = 30
//  TIMEOUT  64   idle cycles before a partial frame is closed; 0 disables timeout
//  TMO_W    8    idle timer width; must hold TIMEOUT
// PORTS
//  clk          in   1   single clock, all logic rising-edge
//  reset_n      in   1   asynchronous, active-low reset
//  atom_valid   in   1   atom offered this cycle
//  atom         in   2   atom value
//  atom_ready   out  1   packer can accept; transfer = atom_valid & atom_ready
//  flush        in   1   close current partial frame (level; sampled each cycle)
//  test_ending  in   1   treated identically to flush
//  dct_valid    out  1   frame register holds a frame
//  dct_ready    in   1   consumer takes frame; transfer = dct_valid & dct_ready
//  dct_buffer   out  30  packed atoms; atom k in bits [2k+1:2k]; unused bits zero
//  dct_count    out  4   number of valid atoms in dct_buffer, 1..15 when dct_valid
//  idle         out  1   acc empty & !dct_valid & !close_pending
// BEHAVIOUR
//  - Reset: acc=0, cnt=0, dct_valid=0, dct_buffer=0, dct_count=0, timer=0, close_pending=0,
//    atom_ready=1, idle=1. Reset mid-frame discards accumulated and presented data.
//  - Accept: acc[2*cnt+:2] <= atom; cnt <= cnt+1; timer <= 0.
//  - Close request when any of: cnt_next==15; (flush|test_ending) & cnt_next>0;
//    TIMEOUT!=0 & timer==TIMEOUT & cnt>0. flush/test_ending with cnt_next==0 is a no-op.
//  - Close: if !dct_valid or dct_ready this cycle, frame reg <= {acc incl. atom accepted this
//    cycle}, dct_count <= cnt_next; acc, cnt, timer cleared. dct_valid is high the cycle after
//    the closing edge (1-cycle latency from the 15th atom).
//  - Close blocked (dct_valid & !dct_ready): set sticky close_pending; acc retained; close
//    performed on first cycle frame reg frees. Further atoms still accepted while cnt<15 and
//    are included in the pending frame.
//  - atom_ready = (cnt<15) | !dct_valid | dct_ready. Never drops atoms.
//  - Timer: increments each cycle with cnt>0 and no accept; saturates at TIMEOUT; cleared on
//    accept or close. Frame appears TIMEOUT+1 cycles after the last accepting edge.
//  - Frame reg: dct_valid falls after transfer unless a new close loads it the same edge
//    (back-to-back frames, no bubble). dct_buffer/dct_count stable while dct_valid & !dct_ready.
//  - Simultaneous accept + flush: atom included, then frame closed.
//  - Order: frames delivered strictly in closure order; atoms within a frame in arrival order.
// STRUCTURE
//  - Package sm_mcu_cpu_dct_pkg: ATOM_W, SLOTS, DCT_W=30, CNT_W=4, atom encodings
//    (ATOM_NT=2'b00, ATOM_TK=2'b01, ATOM_EXC=2'b10, ATOM_SYNC=2'b11).
//  - One sub-module sm_mcu_cpu_dct_idle_timer (clear/inc/saturate, expiry flag); rest flat:
//    accumulator, frame register, close control.
// TESTING
//  1. 15 atoms back-to-back 2'b01, dct_ready=1 -> next cycle dct_valid=1,
//     dct_buffer=30'h15555555, dct_count=15, atom_ready never low.
//  2. Atoms 01,10,11 then flush pulse -> dct_buffer=30'h39, dct_count=3; flush on empty -> no frame.
//  3. dct_ready=0, stream 30 atoms 2'b11 -> first frame held stable, atom_ready low after 30th
//     accept; dct_ready=1 -> two frames 30'h3FFFFFFF count 15, back-to-back, none lost.
//  4. TIMEOUT=4: one atom 2'b10 then silence -> dct_valid rises 5 cycles after accepting edge,
//     dct_buffer=30'h2, dct_count=1; TIMEOUT=0 -> no frame ever.
//  5. Flush while frame reg blocked with 5 atoms, 2 more atoms arrive, then dct_ready -> second
//     frame dct_count=7; test_ending pulse gives same result as flush.
//  6. Assert reset_n low with 9 atoms accumulated and a frame presented -> all outputs to reset
//     values asynchronously, idle=1; after release, first new frame contains only new atoms.

Source files
------------

// File: rtl/sm_mcu_cpu_dct_packer_pkg.sv
// sm_mcu_cpu_dct_pkg: shared widths and atom encodings for the OCI trace packer
package sm_mcu_cpu_dct_pkg;
  localparam int ATOM_W = 2;
  localparam int SLOTS = 15;
  localparam int DCT_W = ATOM_W * SLOTS;
  localparam int CNT_W = 4;
  typedef enum logic [ATOM_W-1:0] {
    ATOM_NT   = 2'b00,
    ATOM_TK   = 2'b01,
    ATOM_EXC  = 2'b10,
    ATOM_SYNC = 2'b11
  } atom_e;
endpackage

// File: rtl/sm_mcu_cpu_dct_packer_if.sv
// sm_mcu_cpu_dct_packer_if: atom input and frame output handshakes of the trace packer
interface sm_mcu_cpu_dct_packer_if;
  import sm_mcu_cpu_dct_pkg::*;
  logic atom_valid;
  logic [ATOM_W-1:0] atom;
  logic atom_ready;
  logic flush;
  logic test_ending;
  logic dct_valid;
  logic dct_ready;
  logic [DCT_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;
  logic idle;
  modport master (
    output atom_valid, atom, flush, test_ending, dct_ready,
    input atom_ready, dct_valid, dct_buffer, dct_count, idle
  );
  modport slave (
    input atom_valid, atom, flush, test_ending, dct_ready,
    output atom_ready, dct_valid, dct_buffer, dct_count, idle
  );
endinterface

// File: rtl/sm_mcu_cpu_dct_idle_timer.sv
// sm_mcu_cpu_dct_idle_timer: saturating idle counter that flags a stale partial frame
module sm_mcu_cpu_dct_idle_timer #(
  parameter int TIMEOUT = 64,
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam logic [TMO_W-1:0] LIM = TMO_W'(TIMEOUT);
  logic [TMO_W-1:0] timer;
  // count idle cycles, holding at the limit so expiry stays asserted until cleared
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) timer <= '0;
    else if (clr) timer <= '0;
    else if (inc && timer != LIM) timer <= timer + TMO_W'(1);
  assign expired = (TIMEOUT != 0) && (timer == LIM);
endmodule

// File: rtl/sm_mcu_cpu_dct_packer.sv
// sm_mcu_cpu_dct_packer: packs 2-bit trace atoms into 30-bit DCT frames with valid/ready output
module sm_mcu_cpu_dct_packer
  import sm_mcu_cpu_dct_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TMO_W = 8
) (
  input logic clk,
  input logic reset_n,
  sm_mcu_cpu_dct_packer_if.slave bus
);
  logic [DCT_W-1:0] acc, acc_in, frame_buf;
  logic [CNT_W-1:0] cnt, cnt_in, frame_cnt;
  logic frame_valid, close_pending, full, can_load, accept, carry, req, load, expired;
  assign full = cnt == CNT_W'(SLOTS);
  assign can_load = !frame_valid || bus.dct_ready;
  assign accept = bus.atom_valid && bus.atom_ready;
  // an atom arriving while a full frame is still waiting starts the next frame
  assign carry = accept && full;
  assign cnt_in = cnt + CNT_W'(accept && !full);
  // accumulator view including the atom accepted this cycle
  always_comb begin
    acc_in = acc;
    if (accept && !full) acc_in[ATOM_W*cnt +: ATOM_W] = bus.atom;
  end
  assign req = (cnt_in == CNT_W'(SLOTS)) || ((bus.flush || bus.test_ending) && cnt_in != '0) ||
               (expired && cnt != '0) || close_pending;
  assign load = req && can_load;
  sm_mcu_cpu_dct_idle_timer #(.TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .clr(accept || load),
    .inc(cnt != '0 && !accept),
    .expired(expired)
  );
  // accumulator, frame register and sticky close request
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
      close_pending <= 1'b0;
      frame_valid <= 1'b0;
      frame_buf <= '0;
      frame_cnt <= '0;
    end else begin
      acc <= load ? (carry ? DCT_W'(bus.atom) : '0) : acc_in;
      cnt <= load ? CNT_W'(carry) : cnt_in;
      close_pending <= req && !can_load;
      frame_valid <= load || (frame_valid && !bus.dct_ready);
      if (load) begin
        frame_buf <= acc_in;
        frame_cnt <= cnt_in;
      end
    end
  assign bus.atom_ready = !full || can_load;
  assign bus.dct_valid = frame_valid;
  assign bus.dct_buffer = frame_buf;
  assign bus.dct_count = frame_cnt;
  assign bus.idle = cnt == '0 && !frame_valid && !close_pending;
endmodule

// File: tb/tb_sm_mcu_cpu_dct_packer.sv
// tb_sm_mcu_cpu_dct_packer: scoreboard bench with a queue-based reference model of the packer
module tb_sm_mcu_cpu_dct_packer;
  import sm_mcu_cpu_dct_pkg::*;
  localparam int TMO = 4;
  logic clk = 0, reset_n = 0, seen0 = 0, ar_low;
  logic [29:0] held;
  logic [33:0] mon_e;
  int n_chk = 0, n_fail = 0, dens_v, dens_r;
  logic [1:0] m_open[$];
  logic [33:0] sb[$];
  bit m_occ, m_pend;
  int m_idle;
  always #5 clk = ~clk;
  sm_mcu_cpu_dct_packer_if bus();
  sm_mcu_cpu_dct_packer_if bus0();
  sm_mcu_cpu_dct_packer #(.TIMEOUT(TMO), .TMO_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  sm_mcu_cpu_dct_packer #(.TIMEOUT(0), .TMO_W(8)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  always @(posedge clk) if (bus0.dct_valid) seen0 <= 1'b1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset;
    m_open.delete();
    sb.delete();
    m_occ = 0;
    m_pend = 0;
    m_idle = 0;
  endtask
  // reference: a frame is the list of atoms since the last close; it closes when 15 atoms,
  // a flush/test_ending, or TMO idle cycles occur, and only moves out once the output is free
  task automatic model_step;
    int n;
    bit free, acc, carry, req;
    logic [29:0] b;
    n = m_open.size();
    free = !m_occ || bus.dct_ready;
    acc = bus.atom_valid && (n < 15 || free);
    carry = acc && n == 15;
    if (acc && !carry) m_open.push_back(bus.atom);
    req = m_open.size() == 15 || ((bus.flush || bus.test_ending) && m_open.size() > 0) ||
          (m_idle >= TMO && n > 0) || m_pend;
    if (req && free) begin
      b = '0;
      foreach (m_open[i]) b = b | (30'(m_open[i]) << (2 * i));
      sb.push_back({4'(m_open.size()), b});
      m_open.delete();
      if (carry) m_open.push_back(bus.atom);
      m_occ = 1;
      m_pend = 0;
      m_idle = 0;
    end else begin
      m_pend = req;
      if (bus.dct_ready) m_occ = 0;
      m_idle = acc ? 0 : (n > 0 ? m_idle + 1 : m_idle);
    end
  endtask
  initial forever begin
    @(posedge clk);
    if (reset_n) model_step();
  end
  // monitor: handshake state every cycle, frame contents on every transfer
  initial forever begin
    @(negedge clk);
    #1;
    if (reset_n) begin
      chk("dct_valid", bus.dct_valid, m_occ);
      chk("atom_ready", bus.atom_ready, m_open.size() < 15 || !m_occ || bus.dct_ready);
      chk("idle", bus.idle, m_open.size() == 0 && !m_occ && !m_pend);
      if (bus.dct_valid && bus.dct_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL frame_unexpected: got buffer %0h with no expected frame", bus.dct_buffer);
        end else begin
          mon_e = sb.pop_front();
          chk("dct_buffer", bus.dct_buffer, mon_e[29:0]);
          chk("dct_count", bus.dct_count, mon_e[33:30]);
        end
      end
    end
  end
  task automatic step(input bit v, input logic [1:0] a, input bit fl, input bit te, input bit rdy);
    @(negedge clk);
    bus.atom_valid = v;
    bus.atom = a;
    bus.flush = fl;
    bus.test_ending = te;
    bus.dct_ready = rdy;
    #1;
  endtask
  task automatic blocked_close(input bit te);
    step(1, 0, 0, 0, 0);
    step(0, 0, !te, te, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    step(0, 0, !te, te, 0);
    step(1, 2, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t5_valid", bus.dct_valid, 1);
    chk("t5_count", bus.dct_count, 7);
    chk("t5_buffer", bus.dct_buffer, 30'h2955);
    step(0, 0, 0, 0, 1);
  endtask
  initial begin
    {bus.atom_valid, bus.atom, bus.flush, bus.test_ending, bus.dct_ready} = '0;
    {bus0.atom_valid, bus0.atom, bus0.flush, bus0.test_ending} = '0;
    bus0.dct_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.dct_valid, 0);
    chk("rst_buffer", bus.dct_buffer, 0);
    chk("rst_count", bus.dct_count, 0);
    chk("rst_ready", bus.atom_ready, 1);
    chk("rst_idle", bus.idle, 1);
    @(negedge clk);
    reset_n = 1;
    ar_low = 0;
    for (int i = 0; i < 15; i++) begin
      step(1, 1, 0, 0, 1);
      if (!bus.atom_ready) ar_low = 1;
    end
    chk("t1_ready_never_low", ar_low, 0);
    step(0, 0, 0, 0, 1);
    chk("t1_valid", bus.dct_valid, 1);
    chk("t1_buffer", bus.dct_buffer, 30'h15555555);
    chk("t1_count", bus.dct_count, 15);
    step(1, 1, 0, 0, 1);
    step(1, 2, 0, 0, 1);
    step(1, 3, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t2_buffer", bus.dct_buffer, 30'h39);
    chk("t2_count", bus.dct_count, 3);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t2_flush_empty", bus.dct_valid, 0);
    for (int i = 0; i < 30; i++) begin
      step(1, 3, 0, 0, 0);
      if (i == 15) held = bus.dct_buffer;
    end
    step(0, 0, 0, 0, 0);
    chk("t3_ready_low", bus.atom_ready, 0);
    chk("t3_held", held, 30'h3FFFFFFF);
    chk("t3_stable", bus.dct_buffer, held);
    step(0, 0, 0, 0, 1);
    chk("t3_f1_count", bus.dct_count, 15);
    step(0, 0, 0, 0, 1);
    chk("t3_f2_valid", bus.dct_valid, 1);
    chk("t3_f2_buffer", bus.dct_buffer, 30'h3FFFFFFF);
    step(0, 0, 0, 0, 1);
    chk("t3_drained", bus.dct_valid, 0);
    step(1, 2, 0, 0, 1);
    bus0.atom_valid = 1;
    bus0.atom = 2;
    for (int j = 1; j <= 6; j++) begin
      step(0, 0, 0, 0, 1);
      bus0.atom_valid = 0;
      chk("t4_timeout_valid", bus.dct_valid, j == 6);
    end
    chk("t4_buffer", bus.dct_buffer, 30'h2);
    chk("t4_count", bus.dct_count, 1);
    repeat (80) step(0, 0, 0, 0, 1);
    chk("t4_tmo0_no_frame", seen0, 0);
    bus0.flush = 1;
    step(0, 0, 0, 0, 1);
    bus0.flush = 0;
    chk("t4_tmo0_flush", bus0.dct_valid, 1);
    chk("t4_tmo0_buffer", bus0.dct_buffer, 30'h2);
    blocked_close(0);
    blocked_close(1);
    for (int i = 0; i < 24; i++) step(1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_pre_idle", bus.idle, 0);
    #2 reset_n = 0;
    #1;
    model_reset();
    chk("t6_valid", bus.dct_valid, 0);
    chk("t6_buffer", bus.dct_buffer, 0);
    chk("t6_count", bus.dct_count, 0);
    chk("t6_ready", bus.atom_ready, 1);
    chk("t6_idle", bus.idle, 1);
    @(negedge clk);
    reset_n = 1;
    repeat (3) step(1, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t6_new_buffer", bus.dct_buffer, 30'h15);
    chk("t6_new_count", bus.dct_count, 3);
    dens_v = 90;
    dens_r = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        dens_v = $urandom_range(5, 100);
        dens_r = $urandom_range(5, 100);
      end
      step($urandom_range(0, 99) < dens_v, 2'($urandom), $urandom_range(0, 40) == 0,
           $urandom_range(0, 60) == 0, $urandom_range(0, 99) < dens_r);
    end
    step(0, 0, 1, 0, 1);
    repeat (20) step(0, 0, 0, 0, 1);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_idle", bus.idle, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
